disp_vramctrl_burst: RTL and testbench

//  Parametrised AXI4 read-address/read-data controller for the display path; successor of the single-burst VRAM controller.

---
 rtl/disp_pkg.sv | 51 +++++
 rtl/disp_outst_cnt.sv | 51 +++++
 rtl/disp_vramctrl_burst.sv | 168 ++++++++++++++++
 tb/tb_disp_vramctrl_burst.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module : disp_pkg
// Brief  : Display fetch resolution codes, FSM encoding and frame-size helpers.
// Rev    : 1.0
// ============================================================================
package disp_pkg;

  typedef enum logic [1:0] {
    RESOL_640  = 2'b00,
    RESOL_800  = 2'b01,
    RESOL_1024 = 2'b10,
    RESOL_RSVD = 2'b11
  } resol_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ADDR  = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DRAIN = 2'b11
  } state_e;

  localparam int c_BCNT_W     = 15;
  localparam int c_PIXEL_BYTES = 4;

  // The reserved code falls back to 640x480.
  function automatic int unsigned res_w(input logic [1:0] resol);
    case (resol)
      RESOL_800:  return 800;
      RESOL_1024: return 1024;
      default:    return 640;
    endcase
  endfunction

  function automatic int unsigned res_h(input logic [1:0] resol);
    case (resol)
      RESOL_800:  return 600;
      RESOL_1024: return 768;
      default:    return 480;
    endcase
  endfunction

  function automatic logic [c_BCNT_W-1:0] nburst(input logic [1:0] resol,
                                                 input int unsigned burst_bytes);
    int unsigned n;
    n = res_w(resol) * res_h(resol) * c_PIXEL_BYTES / burst_bytes;
    return c_BCNT_W'(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/disp_outst_cnt.sv
`default_nettype none
// ============================================================================
// Module : disp_outst_cnt
// Brief  : Outstanding-burst up/down counter with limit and FIFO-space check.
// Rev    : 1.0
// ============================================================================
module disp_outst_cnt #(
  parameter int MAX_OUTST = 4,
  parameter int BURST_LEN = 16,
  parameter int FREE_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic              i_dec,
  input  logic [FREE_W-1:0] i_buf_free,
  output logic              o_nonzero,
  output logic              o_issue_ok
);

  localparam int c_CNT_W = $clog2(MAX_OUTST + 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [31:0]        w_need;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr)
      w_cnt_nxt = '0;
    else if (i_inc && !i_dec)
      w_cnt_nxt = r_cnt + 1'b1;
    else if (!i_inc && i_dec)
      w_cnt_nxt = r_cnt - 1'b1;
  end

  // Judged on the post-update count so the FSM decides for the coming cycle.
  assign w_need     = (32'(w_cnt_nxt) + 32'd1) * 32'(BURST_LEN);
  assign o_issue_ok = (32'(w_cnt_nxt) < 32'(MAX_OUTST)) && (32'(i_buf_free) >= w_need);
  assign o_nonzero  = (r_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else
      r_cnt <= w_cnt_nxt;
  end

endmodule
`default_nettype wire

// File: rtl/disp_vramctrl_burst.sv
`default_nettype none
// ============================================================================
// Module : disp_vramctrl_burst
// Brief  : Multi-outstanding AXI4 burst reader fetching one display frame.
// Rev    : 1.0
// ============================================================================
module disp_vramctrl_burst
  import disp_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 16,
  parameter int MAX_OUTST = 4,
  parameter int FREE_W    = 10
) (
  input  logic              ACLK,
  input  logic              ARST_N,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [1:0]        RESOL,
  input  logic              VRSTART,
  input  logic              DISPON,
  input  logic [28:0]       DISPADDR,
  input  logic [FREE_W-1:0] BUF_FREE,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              VRS_MISS
);

  localparam int c_BEAT_BYTES  = DATA_W / 8;
  localparam int c_BURST_BYTES = BURST_LEN * c_BEAT_BYTES;

  localparam logic [c_BCNT_W-1:0] c_NB_640  = nburst(RESOL_640,  c_BURST_BYTES);
  localparam logic [c_BCNT_W-1:0] c_NB_800  = nburst(RESOL_800,  c_BURST_BYTES);
  localparam logic [c_BCNT_W-1:0] c_NB_1024 = nburst(RESOL_1024, c_BURST_BYTES);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_W-1:0]     r_araddr;
  logic [c_BCNT_W-1:0]   r_issued;
  logic [c_BCNT_W-1:0]   r_done;
  logic [c_BCNT_W-1:0]   r_nburst;
  logic                  r_frame_done;
  logic                  r_vrs_miss;

  logic                  w_ar_hs;
  logic                  w_r_last;
  logic                  w_start;
  logic                  w_issue_ok;
  logic                  w_outst_nz;
  logic [c_BCNT_W-1:0]   w_issued_inc;
  logic [c_BCNT_W-1:0]   w_done_inc;
  logic [c_BCNT_W-1:0]   w_nburst_sel;
  logic [ADDR_W-1:0]     w_base;

  assign w_ar_hs      = ARVALID & ARREADY;
  assign w_r_last     = RVALID & RREADY & RLAST;
  assign w_start      = (r_state == ST_IDLE) & VRSTART & DISPON;
  assign w_issued_inc = r_issued + 1'b1;
  assign w_done_inc   = r_done + 1'b1;

  // Burst-aligned base keeps every burst inside one 4 KB page.
  assign w_base = ADDR_W'({DISPADDR, 3'b000}) & ~(ADDR_W'(c_BURST_BYTES - 1));

  always_comb begin
    case (RESOL)
      RESOL_800:  w_nburst_sel = c_NB_800;
      RESOL_1024: w_nburst_sel = c_NB_1024;
      default:    w_nburst_sel = c_NB_640;
    endcase
  end

  disp_outst_cnt #(
    .MAX_OUTST (MAX_OUTST),
    .BURST_LEN (BURST_LEN),
    .FREE_W    (FREE_W)
  ) u_outst (
    .clk        (ACLK),
    .rst_n      (ARST_N),
    .i_clr      (w_start),
    .i_inc      (w_ar_hs),
    .i_dec      (w_r_last),
    .i_buf_free (BUF_FREE),
    .o_nonzero  (w_outst_nz),
    .o_issue_ok (w_issue_ok)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (VRSTART && DISPON)
          w_state_nxt = w_issue_ok ? ST_ADDR : ST_WAIT;
      end
      ST_ADDR: begin
        // The address phase completes even when DISPON has dropped.
        if (ARREADY) begin
          if ((w_issued_inc == r_nburst) || !DISPON)
            w_state_nxt = ST_DRAIN;
          else if (w_issue_ok)
            w_state_nxt = ST_ADDR;
          else
            w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!DISPON)
          w_state_nxt = ST_DRAIN;
        else if (w_issue_ok)
          w_state_nxt = ST_ADDR;
      end
      ST_DRAIN: begin
        if (!w_outst_nz)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARST_N) begin
    if (!ARST_N)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge ACLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_araddr     <= '0;
      r_issued     <= '0;
      r_done       <= '0;
      r_nburst     <= '0;
      r_frame_done <= 1'b0;
      r_vrs_miss   <= 1'b0;
    end else begin
      r_frame_done <= w_r_last && (w_done_inc == r_nburst);
      r_vrs_miss   <= VRSTART && (r_state != ST_IDLE);
      if (w_start) begin
        r_araddr <= w_base;
        r_issued <= '0;
        r_done   <= '0;
        r_nburst <= w_nburst_sel;
      end else begin
        if (w_ar_hs) begin
          r_araddr <= r_araddr + ADDR_W'(c_BURST_BYTES);
          r_issued <= w_issued_inc;
        end
        if (w_r_last)
          r_done <= w_done_inc;
      end
    end
  end

  assign ARADDR     = r_araddr;
  assign ARLEN      = 8'(BURST_LEN - 1);
  assign ARVALID    = (r_state == ST_ADDR);
  assign RREADY     = w_outst_nz;
  assign BUSY       = (r_state != ST_IDLE);
  assign FRAME_DONE = r_frame_done;
  assign VRS_MISS   = r_vrs_miss;

endmodule
`default_nettype wire

// File: tb/tb_disp_vramctrl_burst.sv
`default_nettype none
// ============================================================================
// Module : tb_disp_vramctrl_burst
// Brief  : Scoreboard bench for the display burst fetch controller.
// Rev    : 1.0
// ============================================================================
module tb_disp_vramctrl_burst;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 64;
  localparam int BURST_LEN = 16;
  localparam int MAX_OUTST = 4;
  localparam int FREE_W    = 10;

  logic              ACLK;
  logic              ARST_N;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic              ARVALID;
  logic              ARREADY;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;
  logic [1:0]        RESOL;
  logic              VRSTART;
  logic              DISPON;
  logic [28:0]       DISPADDR;
  logic [FREE_W-1:0] BUF_FREE;
  logic              BUSY;
  logic              FRAME_DONE;
  logic              VRS_MISS;

  disp_vramctrl_burst #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN),
    .MAX_OUTST (MAX_OUTST),
    .FREE_W    (FREE_W)
  ) dut (
    .ACLK       (ACLK),
    .ARST_N     (ARST_N),
    .ARADDR     (ARADDR),
    .ARLEN      (ARLEN),
    .ARVALID    (ARVALID),
    .ARREADY    (ARREADY),
    .RLAST      (RLAST),
    .RVALID     (RVALID),
    .RREADY     (RREADY),
    .RESOL      (RESOL),
    .VRSTART    (VRSTART),
    .DISPON     (DISPON),
    .DISPADDR   (DISPADDR),
    .BUF_FREE   (BUF_FREE),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE),
    .VRS_MISS   (VRS_MISS)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int          ar_cnt, rl_cnt, outst_tb, max_outst, fd_cnt, miss_cnt;
  int          run_len, max_run, beats_per_burst;
  bit          fd_busy, r_hold;
  longint      cyc, last_ar_cyc;
  logic [31:0] last_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic clear_stats();
    ar_cnt = 0; rl_cnt = 0; outst_tb = 0; max_outst = 0;
    fd_cnt = 0; miss_cnt = 0; fd_busy = 0; max_run = 0; run_len = 0;
  endtask

  task automatic push_frame(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i) * 32'd128);
  endtask

  task automatic start_frame(input logic [1:0] resol, input logic [28:0] daddr);
    RESOL    = resol;
    DISPADDR = daddr;
    VRSTART  = 1'b1;
    tick(1);
    VRSTART  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k;
    k = 0;
    while (BUSY && k < bound) begin
      tick(1);
      k++;
    end
    check(name, BUSY, 0);
  endtask

  // Scoreboard monitor: samples mid-cycle, i.e. the values the next edge will see.
  initial begin
    cyc = 0; last_ar_cyc = -10;
    forever begin
      @(negedge ACLK);
      cyc++;
      if (ARST_N) begin
        if (ARVALID && ARREADY) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL ar_extra: got unexpected AR at 0x%0h, want none", ARADDR);
          end else begin
            check("araddr", ARADDR, exp_q.pop_front());
          end
          check("arlen", ARLEN, 64'd15);
          ar_cnt++;
          outst_tb++;
          last_addr = ARADDR;
          run_len = (cyc == last_ar_cyc + 1) ? run_len + 1 : 1;
          if (run_len > max_run) max_run = run_len;
          last_ar_cyc = cyc;
        end else if (ARVALID && exp_q.size() != 0) begin
          check("araddr_stall", ARADDR, exp_q[0]);
        end
        if (RVALID && RREADY && RLAST) begin
          rl_cnt++;
          outst_tb--;
        end
        if (outst_tb > max_outst) max_outst = outst_tb;
        if (FRAME_DONE) begin
          fd_cnt++;
          fd_busy = BUSY;
        end
        if (VRS_MISS) miss_cnt++;
      end
    end
  end

  // AXI read-data responder: first beat one cycle after the address handshake.
  initial begin
    int beat, pend;
    bit ar_hs, r_hs;
    beat = 0; pend = 0;
    RVALID = 1'b0; RLAST = 1'b0;
    forever begin
      @(negedge ACLK);
      ar_hs = ARVALID && ARREADY && ARST_N;
      r_hs  = RVALID && RREADY && ARST_N;
      @(posedge ACLK);
      #1;
      if (!ARST_N) begin
        pend = 0; beat = 0; RVALID = 1'b0; RLAST = 1'b0;
      end else begin
        if (ar_hs) pend++;
        if (r_hs) begin
          if (RLAST) begin pend--; beat = 0; end
          else beat++;
        end
        RVALID = (pend > 0) && !r_hold;
        RLAST  = RVALID && (beat == beats_per_burst - 1);
      end
    end
  end

  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

  initial begin
    int ar_base;
    int k;
    ARST_N = 1'b0; ARREADY = 1'b1; RESOL = 2'b00; VRSTART = 1'b0; DISPON = 1'b1;
    DISPADDR = '0; BUF_FREE = '1; r_hold = 0; beats_per_burst = 1;
    clear_stats();
    tick(3);
    check("rst_arvalid", ARVALID, 0);
    check("rst_rready", RREADY, 0);
    check("rst_busy", BUSY, 0);
    check("rst_frame_done", FRAME_DONE, 0);
    check("rst_vrs_miss", VRS_MISS, 0);
    check("rst_araddr", ARADDR, 0);
    ARST_N = 1'b1;
    tick(2);

    // Full 640x480 frame with a mid-frame VRSTART and input changes.
    push_frame(32'h1000_0000, 9600);
    start_frame(2'b00, 29'h0200_0000);
    check("t1_vrstart_latency", ARVALID, 1);
    tick(200);
    RESOL = 2'b10; DISPADDR = 29'h0;
    VRSTART = 1'b1;
    tick(1);
    VRSTART = 1'b0;
    wait_idle("t1_idle", 15000);
    tick(2);
    check("t1_ar_count", ar_cnt, 9600);
    check("t1_rlast_count", rl_cnt, 9600);
    check("t1_last_addr", last_addr, 32'h1012_BF80);
    check("t1_frame_done", fd_cnt, 1);
    check("t1_busy_at_done", fd_busy, 1);
    check("t1_vrs_miss", miss_cnt, 1);
    check("t1_max_outst_ok", (max_outst <= MAX_OUTST), 1);
    check("t1_queue_left", exp_q.size(), 0);

    // FIFO space limits to one burst, then allows four back-to-back.
    exp_q.delete();
    clear_stats();
    beats_per_burst = 16;
    BUF_FREE = 10'd16;
    push_frame(32'h0200_0000, 9600);
    start_frame(2'b00, 29'h0040_0000);
    tick(300);
    check("t2_progress", (ar_cnt >= 10), 1);
    check("t2_max_outst", max_outst, 1);
    BUF_FREE = 10'd0;
    k = 0;
    while ((outst_tb != 0 || ARVALID) && k < 500) begin tick(1); k++; end
    check("t2_quiesce", outst_tb, 0);
    r_hold = 1;
    max_run = 0;
    ar_base = ar_cnt;
    BUF_FREE = 10'd64;
    tick(12);
    check("t2_burst_ars", ar_cnt - ar_base, 4);
    check("t2_b2b_run", max_run, 4);
    check("t2_wait_arvalid", ARVALID, 0);
    DISPON = 1'b0;
    r_hold = 0;
    wait_idle("t2_idle", 500);
    check("t2_no_frame_done", fd_cnt, 0);
    check("t2_outst_drained", outst_tb, 0);
    exp_q.delete();
    DISPON = 1'b1;
    BUF_FREE = '1;
    tick(2);

    // Address phase held while ARREADY is low; DISPON drops during the stall.
    clear_stats();
    ARREADY = 1'b0;
    push_frame(32'h0000_9180, 1);
    start_frame(2'b01, 29'h0000_1234);
    for (int i = 0; i < 10; i++) begin
      check("t3_arvalid_hold", ARVALID, 1);
      check("t3_araddr_hold", ARADDR, 32'h0000_9180);
      if (i == 2) DISPON = 1'b0;
      tick(1);
    end
    ARREADY = 1'b1;
    wait_idle("t3_idle", 200);
    check("t3_ar_count", ar_cnt, 1);
    check("t3_rlast_count", rl_cnt, 1);
    check("t3_no_frame_done", fd_cnt, 0);
    DISPON = 1'b1;
    beats_per_burst = 1;
    tick(2);

    // 1024x768 frame from an unaligned base.
    clear_stats();
    push_frame(32'h0800_0000, 24576);
    start_frame(2'b10, 29'h0100_0003);
    wait_idle("t4_idle", 30000);
    tick(2);
    check("t4_ar_count", ar_cnt, 24576);
    check("t4_last_addr", last_addr, 32'h082F_FF80);
    check("t4_frame_done", fd_cnt, 1);
    check("t4_queue_left", exp_q.size(), 0);

    // Asynchronous reset mid-frame, then a reserved-code frame from the base.
    clear_stats();
    push_frame(32'h0400_0000, 15000);
    start_frame(2'b01, 29'h0080_0000);
    tick(50);
    check("t5_pre_ars", (ar_cnt > 0), 1);
    #2;
    ARST_N = 1'b0;
    #1;
    check("t5_rst_arvalid", ARVALID, 0);
    check("t5_rst_rready", RREADY, 0);
    check("t5_rst_busy", BUSY, 0);
    check("t5_rst_frame_done", FRAME_DONE, 0);
    check("t5_rst_vrs_miss", VRS_MISS, 0);
    check("t5_rst_araddr", ARADDR, 0);
    tick(2);
    ARST_N = 1'b1;
    exp_q.delete();
    clear_stats();
    tick(2);
    push_frame(32'h0400_0000, 9600);
    start_frame(2'b11, 29'h0080_0000);
    wait_idle("t5_idle", 15000);
    tick(2);
    check("t5_ar_count", ar_cnt, 9600);
    check("t5_last_addr", last_addr, 32'h0412_BF80);
    check("t5_frame_done", fd_cnt, 1);
    check("t5_queue_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
